// File: rtl/uart_pkg.sv
// uart_pkg
// Shared definitions for the UART frame controller.
//   UART_DATA_W  : default byte width
//   uart_state_t : 2-bit FSM state encoding
package uart_pkg;

    localparam int UART_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        RECEIVE  = 2'b01,
        TRANSMIT = 2'b10,
        WAIT     = 2'b11
    } uart_state_t;

endpackage

// File: rtl/registro_param.sv
// registro_param
// Generic N-bit register with load enable and synchronous clear.
//   i_clk  : clock
//   i_rst  : synchronous active-high clear
//   i_en   : load enable
//   i_d    : data in
//   o_q    : registered data out
module registro_param #(
    parameter int N = 2
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_en,
    input  logic [N-1:0] i_d,
    output logic [N-1:0] o_q
);

    logic [N-1:0] r_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_q <= '0;
        end else if (i_en) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/uart_frame_buffer.sv
// uart_frame_buffer
// FRAME_LEN x DATA_W register file holding one UART frame.
//   i_clk    : clock
//   i_rst    : synchronous clear of all entries
//   i_we     : write enable
//   i_widx   : write index
//   i_wdata  : write data
//   i_ridx   : read index
//   o_rdata  : combinational read data (0 for out-of-range index)
//   o_frame  : all entries flattened, entry 0 in the LSBs
module uart_frame_buffer
    import uart_pkg::*;
#(
    parameter int DATA_W    = UART_DATA_W,
    parameter int FRAME_LEN = 4,
    localparam int IW       = $clog2(FRAME_LEN + 1)
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_we,
    input  logic [IW-1:0]               i_widx,
    input  logic [DATA_W-1:0]           i_wdata,
    input  logic [IW-1:0]               i_ridx,
    output logic [DATA_W-1:0]           o_rdata,
    output logic [FRAME_LEN*DATA_W-1:0] o_frame
);

    logic [DATA_W-1:0] r_mem [FRAME_LEN];

    // Index decode by comparison keeps the index wider than the array
    // without out-of-range accesses.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < FRAME_LEN; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            for (int i = 0; i < FRAME_LEN; i++) begin
                if (i_widx == IW'(i)) begin
                    r_mem[i] <= i_wdata;
                end
            end
        end
    end

    always_comb begin
        o_rdata = '0;
        for (int i = 0; i < FRAME_LEN; i++) begin
            if (i_ridx == IW'(i)) begin
                o_rdata = r_mem[i];
            end
        end
    end

    genvar g;
    generate
        for (g = 0; g < FRAME_LEN; g++) begin : g_flat
            assign o_frame[g*DATA_W +: DATA_W] = r_mem[g];
        end
    endgenerate

endmodule

// File: rtl/uart_frame_fsm.sv
// uart_frame_fsm
// Buffers a FRAME_LEN-byte frame from the UART RX core (start gated by
// i_signal_arduino) and re-sends it byte by byte through the TX core using a
// start/done handshake. Flags inter-byte RX timeout and RX overrun.
//   i_clk, i_rst        : clock, synchronous active-high reset
//   i_rx_done/i_rx_data : RX byte strobe and data
//   i_tx_done           : TX core finished current byte
//   i_signal_arduino    : frame-start enable, looked at only in IDLE
//   o_reg_rx_en         : byte accepted this cycle (combinational)
//   o_tx_start          : start request to TX core
//   o_tx_data           : byte being sent
//   o_frame_data        : buffered frame, byte 0 in the LSBs
//   o_data_ready        : pulse, frame fully transmitted
//   o_frame_err         : pulse, RX inter-byte timeout
//   o_rx_overrun        : pulse, RX byte dropped while transmitting
//   o_busy              : controller not idle
//
// state    | meaning
// IDLE     | waiting for first byte with i_signal_arduino high
// RECEIVE  | collecting remaining bytes, gap timer running
// TRANSMIT | one-cycle tx start request for byte tx_idx
// WAIT     | waiting for i_tx_done of byte tx_idx
module uart_frame_fsm
    import uart_pkg::*;
#(
    parameter int DATA_W      = UART_DATA_W,
    parameter int FRAME_LEN   = 4,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_rx_done,
    input  logic [DATA_W-1:0]           i_rx_data,
    input  logic                        i_tx_done,
    input  logic                        i_signal_arduino,
    output logic                        o_reg_rx_en,
    output logic                        o_tx_start,
    output logic [DATA_W-1:0]           o_tx_data,
    output logic [FRAME_LEN*DATA_W-1:0] o_frame_data,
    output logic                        o_data_ready,
    output logic                        o_frame_err,
    output logic                        o_rx_overrun,
    output logic                        o_busy
);

    localparam int IW = $clog2(FRAME_LEN + 1);
    localparam int GW = $clog2(TIMEOUT_CYC);
    localparam logic [IW-1:0] IDX_LAST = IW'(FRAME_LEN - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(TIMEOUT_CYC - 1);

    uart_state_t w_state;
    uart_state_t w_state_nxt;
    logic [1:0]  w_state_q;

    logic [IW-1:0] r_rx_idx;
    logic [IW-1:0] r_tx_idx;
    logic [GW-1:0] r_gap;
    logic          r_data_ready;
    logic          r_frame_err;
    logic          r_rx_overrun;

    logic          w_capture;
    logic [IW-1:0] w_widx;

    registro_param #(.N(2)) u_state_reg (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_en  (1'b1),
        .i_d   (w_state_nxt),
        .o_q   (w_state_q)
    );

    assign w_state = uart_state_t'(w_state_q);

    assign w_capture = i_rx_done &
                       (((w_state == IDLE) & i_signal_arduino) | (w_state == RECEIVE));
    assign w_widx    = (w_state == IDLE) ? '0 : r_rx_idx;

    uart_frame_buffer #(
        .DATA_W    (DATA_W),
        .FRAME_LEN (FRAME_LEN)
    ) u_buf (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_we    (w_capture),
        .i_widx  (w_widx),
        .i_wdata (i_rx_data),
        .i_ridx  (r_tx_idx),
        .o_rdata (o_tx_data),
        .o_frame (o_frame_data)
    );

    always_comb begin
        w_state_nxt = w_state;
        unique case (w_state)
            IDLE: begin
                if (w_capture) begin
                    w_state_nxt = (FRAME_LEN == 1) ? TRANSMIT : RECEIVE;
                end
            end
            RECEIVE: begin
                // A byte arriving on the timeout cycle takes priority.
                if (i_rx_done) begin
                    if (r_rx_idx == IDX_LAST) begin
                        w_state_nxt = TRANSMIT;
                    end
                end else if (r_gap == GAP_LAST) begin
                    w_state_nxt = IDLE;
                end
            end
            TRANSMIT: w_state_nxt = WAIT;
            WAIT: begin
                if (i_tx_done) begin
                    w_state_nxt = (r_tx_idx == IDX_LAST) ? IDLE : TRANSMIT;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rx_idx     <= '0;
            r_tx_idx     <= '0;
            r_gap        <= '0;
            r_data_ready <= 1'b0;
            r_frame_err  <= 1'b0;
            r_rx_overrun <= 1'b0;
        end else begin
            r_data_ready <= 1'b0;
            r_frame_err  <= 1'b0;
            r_rx_overrun <= i_rx_done & ((w_state == TRANSMIT) | (w_state == WAIT));
            unique case (w_state)
                IDLE: begin
                    r_gap <= '0;
                    if (w_capture) begin
                        r_rx_idx <= IW'(1);
                        r_tx_idx <= '0;
                    end
                end
                RECEIVE: begin
                    if (i_rx_done) begin
                        r_gap    <= '0;
                        r_rx_idx <= r_rx_idx + 1'b1;
                        if (r_rx_idx == IDX_LAST) begin
                            r_tx_idx <= '0;
                        end
                    end else if (r_gap == GAP_LAST) begin
                        r_gap       <= '0;
                        r_rx_idx    <= '0;
                        r_frame_err <= 1'b1;
                    end else begin
                        r_gap <= r_gap + 1'b1;
                    end
                end
                TRANSMIT: begin
                end
                WAIT: begin
                    if (i_tx_done) begin
                        if (r_tx_idx == IDX_LAST) begin
                            r_data_ready <= 1'b1;
                            r_rx_idx     <= '0;
                        end else begin
                            r_tx_idx <= r_tx_idx + 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign o_reg_rx_en  = w_capture;
    assign o_tx_start   = (w_state == TRANSMIT);
    assign o_busy       = (w_state != IDLE);
    assign o_data_ready = r_data_ready;
    assign o_frame_err  = r_frame_err;
    assign o_rx_overrun = r_rx_overrun;

endmodule

// File: tb/tb_uart_frame_fsm.sv
module tb_uart_frame_fsm;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx_done, tx_done, sig;
    logic [7:0]  rx_data;
    logic        reg_rx_en, tx_start, data_ready, frame_err, rx_overrun, busy;
    logic [7:0]  tx_data;
    logic [31:0] frame_data;

    logic        rx1_done, tx1_done, sig1;
    logic [7:0]  rx1_data;
    logic        reg_rx_en1, tx_start1, data_ready1, frame_err1, rx_overrun1, busy1;
    logic [7:0]  tx_data1;
    logic [7:0]  frame_data1;

    int checks   = 0;
    int failures = 0;

    logic [7:0] fb     [4];
    logic [7:0] mframe [4];

    always #5 clk = ~clk;

    uart_frame_fsm #(.DATA_W(8), .FRAME_LEN(4), .TIMEOUT_CYC(16)) dut (
        .i_clk(clk), .i_rst(rst), .i_rx_done(rx_done), .i_rx_data(rx_data),
        .i_tx_done(tx_done), .i_signal_arduino(sig),
        .o_reg_rx_en(reg_rx_en), .o_tx_start(tx_start), .o_tx_data(tx_data),
        .o_frame_data(frame_data), .o_data_ready(data_ready), .o_frame_err(frame_err),
        .o_rx_overrun(rx_overrun), .o_busy(busy)
    );

    uart_frame_fsm #(.DATA_W(8), .FRAME_LEN(1), .TIMEOUT_CYC(16)) dut1 (
        .i_clk(clk), .i_rst(rst), .i_rx_done(rx1_done), .i_rx_data(rx1_data),
        .i_tx_done(tx1_done), .i_signal_arduino(sig1),
        .o_reg_rx_en(reg_rx_en1), .o_tx_start(tx_start1), .o_tx_data(tx_data1),
        .o_frame_data(frame_data1), .o_data_ready(data_ready1), .o_frame_err(frame_err1),
        .o_rx_overrun(rx_overrun1), .o_busy(busy1)
    );

    // Expected frame: byte 0 in the LSBs.
    function automatic logic [31:0] mflat();
        return {mframe[3], mframe[2], mframe[1], mframe[0]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_tx_start"},   32'(tx_start),   32'd0);
        check({tag, "_data_ready"}, 32'(data_ready), 32'd0);
        check({tag, "_frame_err"},  32'(frame_err),  32'd0);
        check({tag, "_overrun"},    32'(rx_overrun), 32'd0);
        check({tag, "_busy"},       32'(busy),       32'd0);
        check({tag, "_tx_data"},    32'(tx_data),    32'd0);
        check({tag, "_frame"},      frame_data,      32'd0);
    endtask

    task automatic send_byte(input logic [7:0] b, input int idx);
        rx_done = 1'b1;
        rx_data = b;
        sig     = 1'b1;
        @(negedge clk);
        check("rx_strobe", 32'(reg_rx_en), 32'd1);
        tick();
        rx_done = 1'b0;
        sig     = 1'($urandom_range(0, 1));
        mframe[idx] = b;
    endtask

    // Send fb[] as a frame, then serve TX. ovr_k: inject an RX byte during
    // WAIT of byte ovr_k. abort_k: reset during WAIT of byte abort_k.
    task automatic run_frame(input int ovr_k, input int abort_k);
        int n;
        for (int i = 0; i < 4; i++) begin
            send_byte(fb[i], i);
            if (i < 3) begin
                n = $urandom_range(0, 3);
                repeat (n) tick();
            end
        end
        sig = 1'b0;
        check("tx_start_latency", 32'(tx_start), 32'd1);
        check("tx_data_0", 32'(tx_data), 32'(fb[0]));
        check("frame_rx", frame_data, mflat());
        for (int k = 0; k < 4; k++) begin
            tick();
            check("tx_start_one_cycle", 32'(tx_start), 32'd0);
            if (k == abort_k) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
                for (int j = 0; j < 4; j++) mframe[j] = 8'h00;
                check_quiet("abort");
                check("abort_rx_en", 32'(reg_rx_en), 32'd0);
                tick();
                check("abort_no_ready", 32'(data_ready), 32'd0);
                return;
            end
            n = $urandom_range(0, 3);
            repeat (n) begin
                tick();
                check("wait_hold", 32'(tx_start), 32'd0);
            end
            if (k == ovr_k) begin
                rx_done = 1'b1;
                rx_data = 8'h55;
                @(negedge clk);
                check("ovr_no_strobe", 32'(reg_rx_en), 32'd0);
                tick();
                rx_done = 1'b0;
                check("ovr_pulse", 32'(rx_overrun), 32'd1);
                check("ovr_tx_data", 32'(tx_data), 32'(fb[k]));
                check("ovr_frame", frame_data, mflat());
                tick();
                check("ovr_pulse_end", 32'(rx_overrun), 32'd0);
            end
            tx_done = 1'b1;
            tick();
            tx_done = 1'b0;
            if (k < 3) begin
                check("tx_next_start", 32'(tx_start), 32'd1);
                check("tx_next_data", 32'(tx_data), 32'(fb[k+1]));
            end else begin
                check("data_ready", 32'(data_ready), 32'd1);
                check("busy_done", 32'(busy), 32'd0);
                check("frame_done", frame_data, mflat());
            end
        end
        tick();
        check("data_ready_end", 32'(data_ready), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        rx_done = 1'b0; tx_done = 1'b0; sig = 1'b0; rx_data = 8'h00;
        rx1_done = 1'b0; tx1_done = 1'b0; sig1 = 1'b0; rx1_data = 8'h00;
        for (int j = 0; j < 4; j++) mframe[j] = 8'h00;
        repeat (2) tick();
        check_quiet("reset");
        check("reset_rx_en", 32'(reg_rx_en), 32'd0);
        check("reset1_busy", 32'(busy1), 32'd0);
        check("reset1_frame", 32'(frame_data1), 32'd0);
        rst = 1'b0;
        tick();

        // Fixed frame.
        fb[0] = 8'h11; fb[1] = 8'h22; fb[2] = 8'h33; fb[3] = 8'h44;
        run_frame(-1, -1);
        check("frame_fixed", frame_data, 32'h44332211);

        // Ungated byte in IDLE.
        rx_done = 1'b1; rx_data = 8'hAA; sig = 1'b0;
        @(negedge clk);
        check("ungated_strobe", 32'(reg_rx_en), 32'd0);
        tick();
        rx_done = 1'b0;
        check("ungated_busy", 32'(busy), 32'd0);
        check("ungated_frame", frame_data, mflat());
        check("ungated_err", 32'(frame_err), 32'd0);

        // Timeout after two bytes.
        for (int i = 0; i < 2; i++) send_byte(8'($urandom), i);
        sig = 1'b0;
        repeat (15) begin
            tick();
            check("gap_busy", 32'(busy), 32'd1);
            check("gap_no_err", 32'(frame_err), 32'd0);
        end
        tick();
        check("timeout_err", 32'(frame_err), 32'd1);
        check("timeout_idle", 32'(busy), 32'd0);
        check("timeout_no_tx", 32'(tx_start), 32'd0);
        check("timeout_partial", frame_data, mflat());
        tick();
        check("timeout_err_end", 32'(frame_err), 32'd0);

        // Retry, random data.
        for (int i = 0; i < 4; i++) fb[i] = 8'($urandom);
        run_frame(-1, -1);

        // Overrun during WAIT.
        for (int i = 0; i < 4; i++) fb[i] = 8'($urandom);
        run_frame(int'($urandom_range(0, 3)), -1);

        // Reset in WAIT after the second tx_start, then a fresh frame.
        for (int i = 0; i < 4; i++) fb[i] = 8'($urandom);
        run_frame(-1, 1);
        for (int i = 0; i < 4; i++) fb[i] = 8'($urandom);
        run_frame(-1, -1);

        // Single-byte frame instance.
        for (int r = 0; r < 2; r++) begin
            logic [7:0] b;
            b = (r == 0) ? 8'h7E : 8'($urandom);
            rx1_done = 1'b1; rx1_data = b; sig1 = 1'b1;
            @(negedge clk);
            check("f1_strobe", 32'(reg_rx_en1), 32'd1);
            tick();
            rx1_done = 1'b0; sig1 = 1'b0;
            check("f1_tx_start", 32'(tx_start1), 32'd1);
            check("f1_tx_data", 32'(tx_data1), 32'(b));
            tick();
            check("f1_tx_start_end", 32'(tx_start1), 32'd0);
            tx1_done = 1'b1;
            tick();
            tx1_done = 1'b0;
            check("f1_ready", 32'(data_ready1), 32'd1);
            check("f1_busy", 32'(busy1), 32'd0);
            check("f1_frame", 32'(frame_data1), 32'(b));
            tick();
            check("f1_ready_end", 32'(data_ready1), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
